// File: rtl/nexys_starship_pkg.sv
// Shared constants and the per-channel seed derivation for the starship RNG bank.
package nexys_starship_pkg;

    localparam logic [31:0] NEXYS_POLY         = 32'h0000_B400;
    localparam logic [31:0] NEXYS_SALT         = 32'h0000_9E37;
    localparam logic [31:0] NEXYS_DEFAULT_SEED = 32'h0000_ACE1;

    // Offsets the base seed by ch*salt, truncates to width bits and never yields zero.
    function automatic logic [31:0] seed_fn(input logic [31:0] base,
                                            input logic [31:0] salt,
                                            input logic [31:0] ch,
                                            input int unsigned width);
        logic [31:0] mask;
        logic [31:0] s;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
        s    = (base + ch * salt) & mask;
        if (s == 32'h0) begin
            s = 32'h1;
        end
        return s;
    endfunction

endpackage

// File: rtl/nexys_starship_lfsr.sv
// One RNG channel: Galois LFSR, threshold compare and enabled-cycle cooldown.
module nexys_starship_lfsr
    import nexys_starship_pkg::*;
#(
    parameter int              WIDTH     = 16,
    parameter int              THRESH_W  = 8,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(NEXYS_POLY),
    parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(NEXYS_DEFAULT_SEED),
    parameter int              COOLDOWN  = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Enable,
    input  logic                Load,
    input  logic [WIDTH-1:0]    Load_Value,
    input  logic [THRESH_W-1:0] Threshold,
    output logic                Event,
    output logic [WIDTH-1:0]    State
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [7:0]       cool_q, cool_d;
    logic             event_q, event_d;
    logic             hit;

    always_comb begin
        state_d = state_q;
        cool_d  = cool_q;
        event_d = 1'b0;
        hit     = (cool_q == 8'd0) && (state_q[THRESH_W-1:0] < Threshold);
        if (Load) begin
            state_d = Load_Value;
            cool_d  = 8'd0;
        end else if (Enable) begin
            event_d = hit;
            state_d = state_q[0] ? ((state_q >> 1) ^ POLY) : (state_q >> 1);
            // Cooldown saturates at zero; a hit reloads it.
            if (hit) begin
                cool_d = 8'(COOLDOWN);
            end else if (cool_q != 8'd0) begin
                cool_d = cool_q - 8'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RST_SEED;
            cool_q  <= 8'd0;
            event_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cool_q  <= cool_d;
            event_q <= event_d;
        end
    end

    assign Event = event_q;
    assign State = state_q;

endmodule

// File: rtl/nexys_starship_rng_bank.sv
// Bank of independent LFSR spawn channels with runtime seed, threshold and cooldown.
module nexys_starship_rng_bank
    import nexys_starship_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          WIDTH        = 16,
    parameter int          THRESH_W     = 8,
    parameter logic [31:0] POLY         = NEXYS_POLY,
    parameter logic [31:0] SALT         = NEXYS_SALT,
    parameter logic [31:0] DEFAULT_SEED = NEXYS_DEFAULT_SEED,
    parameter int          COOLDOWN     = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Enable,
    input  logic                Seed_Load,
    input  logic [WIDTH-1:0]    Seed,
    input  logic [THRESH_W-1:0] Threshold,
    output logic [NUM_CH-1:0]   Rand_Event,
    output logic [WIDTH-1:0]    Rand_Value
);

    localparam logic [WIDTH-1:0] POLY_W = POLY[WIDTH-1:0];

    logic [WIDTH-1:0] load_value [NUM_CH];
    logic [WIDTH-1:0] state      [NUM_CH];
    logic [WIDTH-1:0] rand_value_q, rand_value_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [WIDTH-1:0] RST_SEED =
            WIDTH'(seed_fn(DEFAULT_SEED, SALT, 32'(i), WIDTH));

        assign load_value[i] = WIDTH'(seed_fn(32'(Seed), SALT, 32'(i), WIDTH));

        nexys_starship_lfsr #(
            .WIDTH    (WIDTH),
            .THRESH_W (THRESH_W),
            .POLY     (POLY_W),
            .RST_SEED (RST_SEED),
            .COOLDOWN (COOLDOWN)
        ) u_lfsr (
            .Clk        (Clk),
            .Reset      (Reset),
            .Enable     (Enable),
            .Load       (Seed_Load),
            .Load_Value (load_value[i]),
            .Threshold  (Threshold),
            .Event      (Rand_Event[i]),
            .State      (state[i])
        );
    end

    // Mirrors channel 0's next state so Rand_Value lands on the same edge.
    always_comb begin
        rand_value_d = rand_value_q;
        if (Seed_Load) begin
            rand_value_d = load_value[0];
        end else if (Enable) begin
            rand_value_d = state[0][0] ? ((state[0] >> 1) ^ POLY_W) : (state[0] >> 1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rand_value_q <= '0;
        end else begin
            rand_value_q <= rand_value_d;
        end
    end

    assign Rand_Value = rand_value_q;

endmodule

// File: tb/tb_nexys_starship_rng_bank.sv
// Self-checking bench: vector table, statistics, cooldown, period and randomized model compare.
module tb_nexys_starship_rng_bank;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic        Seed_Load = 1'b0;
    logic [15:0] Seed = 16'h0;
    logic [7:0]  Threshold = 8'h0;
    logic [3:0]  ev0, ev3;
    logic [15:0] rv0, rv3;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    nexys_starship_rng_bank #(.COOLDOWN(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Seed_Load(Seed_Load),
        .Seed(Seed), .Threshold(Threshold), .Rand_Event(ev0), .Rand_Value(rv0));

    nexys_starship_rng_bank #(.COOLDOWN(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Seed_Load(Seed_Load),
        .Seed(Seed), .Threshold(Threshold), .Rand_Event(ev3), .Rand_Value(rv3));

    // Reference model: cooldown expressed as "enabled cycles since last event".
    localparam int CD [2] = '{0, 3};
    logic [15:0] m_st   [2][4];
    int          m_last [2][4];
    int          en_cnt = 0;
    logic [3:0]  e_ev   [2];
    logic [15:0] e_rv   [2];

    function automatic logic [15:0] seedf(input logic [15:0] b, input int ch);
        logic [15:0] s;
        s = 16'(b + 16'(ch) * 16'h9E37);
        return (s == 16'h0) ? 16'h1 : s;
    endfunction

    function automatic logic [15:0] stepf(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (Reset) begin
                    m_st[d][i] = seedf(16'hACE1, i);
                    m_last[d][i] = -100000;
                    e_ev[d][i] = 1'b0;
                end else if (Seed_Load) begin
                    m_st[d][i] = seedf(Seed, i);
                    m_last[d][i] = -100000;
                    e_ev[d][i] = 1'b0;
                end else if (Enable) begin
                    e_ev[d][i] = ((en_cnt - m_last[d][i]) > CD[d]) && (int'(m_st[d][i] % 256) < int'(Threshold));
                    if (e_ev[d][i]) m_last[d][i] = en_cnt;
                    m_st[d][i] = stepf(m_st[d][i]);
                end else begin
                    e_ev[d][i] = 1'b0;
                end
            end
            if (Reset) e_rv[d] = 16'h0;
            else if (Seed_Load || Enable) e_rv[d] = m_st[d][0];
        end
        if (!Reset && !Seed_Load && Enable) en_cnt++;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        chk("ev_cd0", 16'(ev0), 16'(e_ev[0]));
        chk("rv_cd0", rv0, e_rv[0]);
        chk("ev_cd3", 16'(ev3), 16'(e_ev[1]));
        chk("rv_cd3", rv3, e_rv[1]);
    endtask

    typedef struct {
        logic        rst;
        logic        ld;
        logic        en;
        logic [15:0] seed;
        logic [15:0] exp_rv;
        logic [15:0] exp_s1;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int cnt [4];
        int diff;
        int last3 [4];
        int idx;
        bit seen;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h4B18};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'hE270, 16'h258C};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h7138, 16'h12C6};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 16'h9E37};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h9E37};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'hB400, 16'hFB1B};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'h1234, 16'hB06B};

        #2;
        Threshold = 8'd0;
        for (int k = 0; k < 7; k++) begin
            Reset = tbl[k].rst; Seed_Load = tbl[k].ld; Enable = tbl[k].en; Seed = tbl[k].seed;
            tick();
            chk("tbl_rv", rv0, tbl[k].exp_rv);
            chk("tbl_s1", dut0.g_ch[1].u_lfsr.state_q, tbl[k].exp_s1);
            chk("tbl_ev", 16'(ev0), 16'h0);
        end
        Seed_Load = 1'b0; Reset = 1'b0;

        // Threshold zero: never an event.
        Enable = 1'b1; Threshold = 8'd0;
        diff = 0;
        for (int k = 0; k < 10000; k++) begin
            tick();
            if (ev0 != 4'h0 || ev3 != 4'h0) diff++;
        end
        chk("thr0_events", 16'(diff), 16'h0);

        // Threshold half: rate and channel independence.
        Threshold = 8'd128;
        cnt = '{0, 0, 0, 0};
        diff = 0;
        for (int k = 0; k < 4096; k++) begin
            tick();
            for (int i = 0; i < 4; i++) cnt[i] += int'(ev0[i]);
            if (ev0[0] != ev0[1]) diff++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnt[i] < 1850 || cnt[i] > 2250) begin
                errors++;
                $display("FAIL rate_ch%0d: got %0d events expected 1850..2250", i, cnt[i]);
            end
        end
        checks++;
        if (diff == 0) begin
            errors++;
            $display("FAIL chan_distinct: got %0d differing cycles expected >0", diff);
        end

        // Cooldown 3, near-certain hits: spacing of at least 4.
        Threshold = 8'd255;
        last3 = '{-100, -100, -100, -100};
        for (int k = 0; k < 200; k++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (ev3[i]) begin
                    chk("cd_gap_ok", 16'((k - last3[i]) >= 4), 16'h1);
                    last3[i] = k;
                end
            end
        end

        // Hold cooldown across a 5-cycle Enable drop.
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            tick();
            seen = ev3[0];
        end
        chk("cd_event_seen", 16'(seen), 16'h1);
        tick();
        chk("cd_hold_a", 16'(ev3[0]), 16'h0);
        Enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("cd_hold_idle", 16'(ev3[0]), 16'h0);
        end
        Enable = 1'b1;
        tick();
        chk("cd_hold_b", 16'(ev3[0]), 16'h0);
        tick();
        chk("cd_hold_c", 16'(ev3[0]), 16'h0);
        tick();
        tick();

        // Reset with cooldowns pending.
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            tick();
            seen = (ev3 != 4'h0);
        end
        chk("rst_pre_event", 16'(seen), 16'h1);
        Reset = 1'b1;
        tick();
        chk("rst_ev", 16'(ev3), 16'h0);
        chk("rst_rv", rv3, 16'h0000);
        chk("rst_s0", dut3.g_ch[0].u_lfsr.state_q, 16'hACE1);
        Reset = 1'b0;
        tick();
        chk("rst_rv1", rv3, 16'hE270);
        chk("rst_ev1", 16'(ev3), 16'hF);
        tick();
        chk("rst_rv2", rv3, 16'h7138);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            Enable    = ($urandom % 4) != 0;
            Threshold = 8'($urandom);
            Seed_Load = ($urandom % 50) == 0;
            Reset     = ($urandom % 200) == 0;
            Seed      = 16'($urandom);
            tick();
        end
        Reset = 1'b0;

        // Full period from state 0001 via Seed_Load of zero with Enable high.
        Seed_Load = 1'b1; Seed = 16'h0000; Enable = 1'b1; Threshold = 8'd0;
        tick();
        chk("ld0_s0", dut0.g_ch[0].u_lfsr.state_q, 16'h0001);
        chk("ld0_s1", dut0.g_ch[1].u_lfsr.state_q, 16'h9E37);
        chk("ld0_ev", 16'(ev0), 16'h0);
        Seed_Load = 1'b0;
        diff = 0;
        idx = 0;
        for (int k = 1; k <= 65535; k++) begin
            tick();
            if (rv0 == 16'h0) diff++;
            if (rv0 == 16'h0001 && k < 65535) idx++;
        end
        chk("period_zero", 16'(diff), 16'h0);
        chk("period_early", 16'(idx), 16'h0);
        chk("period_end", rv0, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nexys_starship_rng_bank.md
Name: nexys_starship_rng_bank

Overview:
- Parametrised bank of NUM_CH independent Galois LFSR channels; each channel produces a one-cycle random "spawn" pulse with a programmable probability and a per-channel cooldown.
- Successor to the fixed four-direction adder-mix random generator.
- Feeds the game-control FSM, which uses one channel per spawn direction: top, bottom, left, right.
- Adds runtime seeding, a runtime probability threshold, enable gating, cooldown and lock-up protection.

Parameters:
- NUM_CH, 4: number of channels (1..16).
- WIDTH, 16: LFSR width in bits (>= THRESH_W + 1).
- THRESH_W, 8: width of the Threshold compare.
- POLY, 16'hB400: Galois feedback mask; the default is maximal-length for WIDTH=16 (x^16+x^14+x^13+x^11+1).
- SALT, 16'h9E37: per-channel seed offset, truncated to WIDTH.
- DEFAULT_SEED, 16'hACE1: seed used at reset.
- COOLDOWN, 0: enabled cycles suppressed after an event (0..255).

Ports:
- Clk, input, 1: system clock.
- Reset, input, 1: synchronous, active-high reset.
- Enable, input, 1: advance LFSRs and cooldowns this cycle (game tick).
- Seed_Load, input, 1: load all channels from Seed this cycle.
- Seed, input, WIDTH: base seed.
- Threshold, input, THRESH_W: event probability is Threshold / 2^THRESH_W.
- Rand_Event, output, NUM_CH: one-cycle event pulses, registered.
- Rand_Value, output, WIDTH: registered copy of the channel-0 LFSR state.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high and is sampled only on the rising edge of Clk.
- Per-channel seed function, for base seed B and channel i:
  - s_i = (B + i*SALT) mod 2^WIDTH.
  - If s_i == 0, use 1 instead. A zero state never exists.
- Priority each rising edge: Reset > Seed_Load > Enable > idle.
- Reset:
  - state_i = seed function of DEFAULT_SEED.
  - cool_i = 0, Rand_Event = 0, Rand_Value = 0.
- Seed_Load=1:
  - state_i = seed function of Seed; cool_i = 0; Rand_Event = 0.
  - Rand_Value = new state_0.
  - Enable is ignored that cycle.
- Enable=1, per channel, all in parallel, using pre-edge values:
  - hit_i = (cool_i == 0) && (state_i[THRESH_W-1:0] < Threshold). The compare is unsigned.
  - Rand_Event[i] <= hit_i.
  - Step: if state_i[0] == 1, state_i <= (state_i >> 1) ^ POLY; otherwise state_i <= state_i >> 1.
  - If hit_i, cool_i <= COOLDOWN. Else if cool_i != 0, cool_i <= cool_i - 1.
  - Rand_Value <= stepped state_0.
- Enable=0 (idle): state, cool and Rand_Value hold; Rand_Event <= 0.
- Latency: the event decision is visible on Rand_Event the edge after the Enable cycle. Rand_Event is never high for two consecutive cycles when COOLDOWN >= 1.
- Boundaries:
  - Threshold = 0: no events, ever.
  - Threshold = 2^THRESH_W - 1: probability (2^THRESH_W - 1) / 2^THRESH_W.
  - A Threshold change takes effect on the next Enable cycle; no glitching.
  - COOLDOWN = 0: no suppression.
  - Cooldown counts enabled cycles only. After an event at enabled cycle t, the next possible event is at enabled cycle t + COOLDOWN + 1.
  - The cooldown counter saturates at 0 and never wraps.
  - LFSR period is 2^WIDTH - 1 for a maximal POLY; the state never reaches 0.
  - Reset or Seed_Load during a cooldown clears it immediately.

Decomposition:
- Shared package (nexys_starship_pkg): default POLY, SALT, DEFAULT_SEED constants, and the seed-function helper function (add, zero-fix).
- Sub-module nexys_starship_lfsr: one channel.
  - Contains state register, step logic, seed load and cooldown counter.
  - Ports: Clk, Reset, Enable, Load, Load_Value, Threshold, Event, State.
  - Instantiated NUM_CH times in a generate loop.
- The top level computes per-channel seeds and registers Rand_Value.

Test Plan:
- Reset, then a single Enable, defaults:
  - After reset, state_0 = ACE1.
  - After one Enable, Rand_Value = E270; after a second Enable, Rand_Value = 7138.
  - State_1 after reset = 0x4B18 (ACE1 + 9E37).
- Threshold = 0, Enable held high for 10000 cycles -> Rand_Event stays 0 on all channels.
- Threshold = 128, COOLDOWN = 0, 4096 enabled cycles -> each channel counts between 1850 and 2250 events; channels are not identical sequences.
- COOLDOWN = 3, Threshold = 255, Enable high -> no two events on any channel fewer than 4 cycles apart; near-periodic 1,0,0,0 pattern. Drop Enable for 5 cycles mid-cooldown -> cooldown resumes where it was held.
- Seed_Load with Seed = 0 and Enable = 1 in the same cycle -> state_0 = 0001, state_1 = 9E37, Rand_Event = 0 that cycle; from state_0 = 0001, 65535 Enables return state_0 to 0001, with no all-zero state in between.
- Reset asserted mid-run with an event pending and cooldowns nonzero:
  - Next edge: Rand_Event = 0, Rand_Value = 0, channel 0 state = ACE1.
  - First Enable afterwards behaves exactly as in the first scenario.
